debounce_edge: RTL and testbench

- Single-bit conditioning stage that sits directly downstream of the async-reset D flip-flop and consumes its registered Q output.
- Filters glitches by requiring the input to hold a new level for a programmable number of consecutive clock edges before the output follows.
- Emits one-cycle rise and fall pulses and keeps a wrapping transition counter for downstream control logic.

---
 rtl/debounce_edge.sv | 131 +++++++++++++
 tb/tb_debounce_edge.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Debounces a single-bit level. It emits registered rise/fall pulses and keeps a wrapping
// count of accepted transitions.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4,
  parameter logic        INIT          = 1'b0,
  parameter int unsigned EVT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  output logic             Q,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam state_t           RST_STATE = INIT ? IDLE_HI : IDLE_LO;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             SINGLE    = (STABLE_CYCLES == 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             q_n, rise_n, fall_n, busy_n;
  logic [EVT_W-1:0] evt_n;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      cnt     <= '0;
      Q       <= INIT;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
      evt_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      Q       <= q_n;
      rise    <= rise_n;
      fall    <= fall_n;
      busy    <= busy_n;
      evt_cnt <= evt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = Q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    evt_n   = evt_cnt;

    unique case (state)
      IDLE_LO: begin
        cnt_n = '0;
        if (D) begin
          if (SINGLE) begin
            state_n = IDLE_HI;
            q_n     = 1'b1;
            rise_n  = 1'b1;
            evt_n   = evt_cnt + EVT_W'(1);
          end else begin
            state_n = WAIT_HI;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      WAIT_HI: begin
        if (!D) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
        end else if (cnt == LAST_CNT) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
          q_n     = 1'b1;
          rise_n  = 1'b1;
          evt_n   = evt_cnt + EVT_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        cnt_n = '0;
        if (!D) begin
          if (SINGLE) begin
            state_n = IDLE_LO;
            q_n     = 1'b0;
            fall_n  = 1'b1;
            evt_n   = evt_cnt + EVT_W'(1);
          end else begin
            state_n = WAIT_LO;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      WAIT_LO: begin
        if (D) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
        end else if (cnt == LAST_CNT) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
          q_n     = 1'b0;
          fall_n  = 1'b1;
          evt_n   = evt_cnt + EVT_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = RST_STATE;
        cnt_n   = '0;
      end
    endcase

    busy_n = (state_n == WAIT_HI) || (state_n == WAIT_LO);
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: stimulus queues expected pulses, a monitor checks them
module tb_debounce_edge;

  localparam int unsigned STABLE = 4;
  localparam int unsigned EVT_W  = 8;

  typedef struct {
    logic             rise;
    logic             q;
    logic [EVT_W-1:0] evt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             D   = 1'b1;
  logic             Q, rise, fall, busy;
  logic [EVT_W-1:0] evt_cnt;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_err    = 0;
  logic             exp_q    = 1'b0;
  logic             exp_busy = 1'b0;
  logic [EVT_W-1:0] exp_evt  = '0;
  logic [EVT_W-1:0] evt_start;

  debounce_edge #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4),
    .INIT         (1'b0),
    .EVT_W        (EVT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .D      (D),
    .Q      (Q),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy),
    .evt_cnt(evt_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: every rise/fall must match the next queued expectation
  always @(posedge clk) begin
    #1;
    if (rise || fall) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_rise", int'(rise), int'(e.rise));
        chk("pulse_fall", int'(fall), int'(!e.rise));
        chk("pulse_q", int'(Q), int'(e.q));
        chk("pulse_evt", int'(evt_cnt), int'(e.evt));
      end
    end
  end

  // Called at a negedge; drives D=v for n edges and checks Q/busy/evt_cnt after each edge
  task automatic drive_level(input logic v, input int n);
    exp_t item;
    D = v;
    if (v != exp_q && n >= STABLE) begin
      item.rise = v;
      item.q    = v;
      item.evt  = exp_evt + 8'd1;
      sb.push_back(item);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (v != exp_q) begin
        if (k == STABLE) begin
          exp_q    = v;
          exp_evt  = exp_evt + 8'd1;
          exp_busy = 1'b0;
        end else begin
          exp_busy = 1'b1;
        end
      end else begin
        exp_busy = 1'b0;
      end
      chk("Q", int'(Q), int'(exp_q));
      chk("busy", int'(busy), int'(exp_busy));
      chk("evt_cnt", int'(evt_cnt), int'(exp_evt));
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held with D=1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_Q", int'(Q), 0);
      chk("rst_rise", int'(rise), 0);
      chk("rst_fall", int'(fall), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_evt", int'(evt_cnt), 0);
    end
    D   = 1'b0;
    rst = 1'b0;
    drive_level(1'b0, 2);
    // Qualified rise
    drive_level(1'b1, 6);
    // Qualified fall
    drive_level(1'b0, 6);
    // Glitch: 3 edges high then back low
    drive_level(1'b1, 3);
    drive_level(1'b0, 3);
    // Glitch from the high side
    drive_level(1'b1, 5);
    drive_level(1'b0, 3);
    drive_level(1'b1, 2);
    drive_level(1'b0, 5);
    // 256 back-to-back qualified transitions wrap evt_cnt
    evt_start = exp_evt;
    for (int t = 0; t < 256; t++) drive_level(~exp_q, STABLE);
    chk("evt_wrap", int'(evt_cnt), int'(evt_start));
    drive_level(exp_q, 2);
    // Reset aborts WAIT_HI mid-qualification
    D = 1'b1;
    @(posedge clk);
    #1;
    chk("w_busy1", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("w_busy2", int'(busy), 1);
    chk("w_Q2", int'(Q), 0);
    #4;
    rst = 1'b1;
    #1;
    chk("arst_Q", int'(Q), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_evt", int'(evt_cnt), 0);
    chk("arst_rise", int'(rise), 0);
    exp_q   = 1'b0;
    exp_evt = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_level(1'b1, 6);
    drive_level(1'b1, 2);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
